// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: CPU single-pixel writes share the port with a
// rectangle-fill engine; the CPU has priority, with a burst limit so fills cannot starve.
module fb_write_sched #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int CPU_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [19:0] cpu_pixel,
  input  logic [23:0] cpu_color,
  output logic        cpu_ack,
  input  logic        fill_start,
  input  logic [9:0]  fill_x0,
  input  logic [9:0]  fill_y0,
  input  logic [10:0] fill_w,
  input  logic [10:0] fill_h,
  input  logic [23:0] fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        fb_write,
  output logic [19:0] fb_pixel,
  output logic [23:0] fb_color
);

  localparam int BW = $clog2(CPU_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CPU_BURST);
  localparam logic [11:0]   H12       = 12'(H_ACTIVE);
  localparam logic [11:0]   V12       = 12'(V_ACTIVE);
  localparam logic [19:0]   H20       = 20'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state_q, state_d;

  logic [9:0]    x0_q, x0_d;
  logic [9:0]    xe_m1_q, xe_m1_d;
  logic [9:0]    ye_m1_q, ye_m1_d;
  logic [9:0]    cur_x_q, cur_x_d;
  logic [9:0]    cur_y_q, cur_y_d;
  logic [19:0]   row_base_q, row_base_d;
  logic [23:0]   color_q, color_d;
  logic          empty_q, empty_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          fb_write_q, fb_write_d;
  logic [19:0]   fb_pixel_q, fb_pixel_d;
  logic [23:0]   fb_color_q, fb_color_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          fill_busy_q, fill_busy_d;
  logic          fill_done_q, fill_done_d;

  // Clip window computed from the raw command at accept time.
  logic [11:0] x_sum, y_sum, xe_new, ye_new;
  logic        empty_new;

  assign x_sum     = {2'b00, fill_x0} + {1'b0, fill_w};
  assign y_sum     = {2'b00, fill_y0} + {1'b0, fill_h};
  assign xe_new    = (x_sum < H12) ? x_sum : H12;
  assign ye_new    = (y_sum < V12) ? y_sum : V12;
  assign empty_new = (fill_w == 11'd0) || (fill_h == 11'd0) ||
                     ({2'b00, fill_x0} >= H12) || ({2'b00, fill_y0} >= V12);

  logic cpu_elig, fill_elig, cpu_win, fill_win, last_col, last_pix;

  // The ack register blocks the CPU for one cycle so a held request is not issued twice.
  assign cpu_elig  = cpu_req && !cpu_ack_q;
  assign fill_elig = (state_q == FILL) && !empty_q;
  assign cpu_win   = cpu_elig && (!fill_elig || (burst_q != BURST_MAX));
  assign fill_win  = fill_elig && !cpu_win;
  assign last_col  = (cur_x_q == xe_m1_q);
  assign last_pix  = last_col && (cur_y_q == ye_m1_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fill_start) state_d = FILL;
      FILL:    if (empty_q || (fill_win && last_pix)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x0_d        = x0_q;
    xe_m1_d     = xe_m1_q;
    ye_m1_d     = ye_m1_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    row_base_d  = row_base_q;
    color_d     = color_q;
    empty_d     = empty_q;
    burst_d     = burst_q;
    fb_write_d  = cpu_win || fill_win;
    fb_pixel_d  = fb_pixel_q;
    fb_color_d  = fb_color_q;
    cpu_ack_d   = cpu_win;
    fill_busy_d = (state_q != IDLE);
    fill_done_d = (state_q == DONE);

    if (state_q == IDLE && fill_start) begin
      x0_d       = fill_x0;
      cur_x_d    = fill_x0;
      cur_y_d    = fill_y0;
      xe_m1_d    = 10'(xe_new - 12'd1);
      ye_m1_d    = 10'(ye_new - 12'd1);
      row_base_d = 20'(fill_y0) * H20;
      color_d    = fill_color;
      empty_d    = empty_new;
    end else if (fill_win) begin
      if (last_col) begin
        cur_x_d    = x0_q;
        cur_y_d    = cur_y_q + 10'd1;
        row_base_d = row_base_q + H20;
      end else begin
        cur_x_d = cur_x_q + 10'd1;
      end
    end

    // Count CPU wins only while the fill is actually being held off.
    if (!fill_elig || fill_win) begin
      burst_d = '0;
    end else if (cpu_win) begin
      burst_d = burst_q + 1'b1;
    end

    if (cpu_win) begin
      fb_pixel_d = cpu_pixel;
      fb_color_d = cpu_color;
    end else if (fill_win) begin
      fb_pixel_d = row_base_q + {10'd0, cur_x_q};
      fb_color_d = color_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q        <= '0;
      xe_m1_q     <= '0;
      ye_m1_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      row_base_q  <= '0;
      color_q     <= '0;
      empty_q     <= 1'b0;
      burst_q     <= '0;
      fb_write_q  <= 1'b0;
      fb_pixel_q  <= '0;
      fb_color_q  <= '0;
      cpu_ack_q   <= 1'b0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      x0_q        <= x0_d;
      xe_m1_q     <= xe_m1_d;
      ye_m1_q     <= ye_m1_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      row_base_q  <= row_base_d;
      color_q     <= color_d;
      empty_q     <= empty_d;
      burst_q     <= burst_d;
      fb_write_q  <= fb_write_d;
      fb_pixel_q  <= fb_pixel_d;
      fb_color_q  <= fb_color_d;
      cpu_ack_q   <= cpu_ack_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign fb_write  = fb_write_q;
  assign fb_pixel  = fb_pixel_q;
  assign fb_color  = fb_color_q;
  assign cpu_ack   = cpu_ack_q;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Arbitrates the single framebuffer write port (write strobe, 20-bit pixel index, 24-bit colour) between two requesters: CPU single-pixel writes and a built-in rectangle-fill engine.
- Sits in the clk domain, directly in front of the video controller's write port.
- The fill engine walks a clipped rectangle row-major, one pixel per granted cycle.
- CPU has priority, with a burst limit so that fills cannot starve.

Parameters:
- H_ACTIVE, 800, visible pixels per line; also the row stride of the pixel index.
- V_ACTIVE, 600, visible lines.
- CPU_BURST, 4, maximum consecutive CPU grants while a fill is pending before the fill is forced one slot.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU write request; held until cpu_ack.
- cpu_pixel  in  20  linear pixel index for the CPU write.
- cpu_color  in  24  RGB colour for the CPU write.
- cpu_ack  out  1  one-cycle pulse; the CPU write has been issued.
- fill_start  in  1  one-cycle command strobe.
- fill_x0  in  10  rectangle left column.
- fill_y0  in  10  rectangle top line.
- fill_w  in  11  rectangle width in pixels.
- fill_h  in  11  rectangle height in lines.
- fill_color  in  24  fill colour.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse at fill completion.
- fb_write  out  1  framebuffer write strobe.
- fb_pixel  out  20  framebuffer pixel index.
- fb_color  out  24  framebuffer colour.

Behaviour:
- All outputs are registered.
- Reset: fb_write=0, fb_pixel=0, fb_color=0, cpu_ack=0, fill_busy=0, fill_done=0; FSM=IDLE; burst counter=0. Reset asserted mid-fill aborts the fill immediately; no further writes are issued.
- FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start=1 latches the command and moves to FILL. fill_start in FILL or DONE is ignored.
  - On accept, compute the clipped rectangle:
    - xe = min(x0+w, H_ACTIVE); ye = min(y0+h, V_ACTIVE), using 12-bit sums.
    - The rectangle is empty if w==0, h==0, x0>=H_ACTIVE or y0>=V_ACTIVE.
    - Latch cur_x=x0, cur_y=y0, row_base=y0*H_ACTIVE (20-bit).
  - FILL, empty rectangle: no writes; go to DONE on the next cycle.
  - FILL, otherwise: each fill grant issues pixel row_base+cur_x.
    - Then cur_x++.
    - When cur_x reaches xe-1 and is written: cur_x=x0, cur_y++, row_base+=H_ACTIVE.
    - The grant that writes pixel (xe-1, ye-1) moves to DONE.
  - DONE: lasts one cycle with fill_done=1, then IDLE.
- fill_busy: 1 from the cycle after fill_start is accepted through the DONE cycle inclusive.
- Arbitration, evaluated every cycle:
  - The CPU is eligible when cpu_req=1 and cpu_ack=0. Ack blocking prevents a double issue, so the CPU gets at most one write per 2 cycles.
  - The fill is eligible in FILL with a non-empty rectangle remaining.
  - Both eligible: the CPU wins unless the burst counter == CPU_BURST, in which case the fill wins.
  - The burst counter increments on each CPU win while the fill is eligible. It clears on any fill win and whenever the fill is not eligible.
- Issue latency: the grant occurs in cycle N; fb_write, fb_pixel and fb_color are valid in cycle N+1.
  - For a CPU grant, cpu_ack=1 in N+1 and cpu_pixel/cpu_color are passed through unchanged. cpu_pixel values of 480000 or more are not checked.
  - For a fill grant, fb_color=latched fill_color.
- No grant: fb_write=0; fb_pixel and fb_color hold their previous values.
- Earliest first fill write: fill_start in cycle 0, FILL in cycle 1, fb_write in cycle 2.
- Last fill write occurs in the same cycle as entry to DONE, so fill_done is asserted one cycle after that write appears.

Test Plan:
- Basic fill: fill_x0=10, y0=5, w=2, h=2, color=0xFF0000, no CPU traffic.
  - Required: fb_write in 4 consecutive cycles starting 2 cycles after fill_start.
  - Pixels 4010, 4011, 4810, 4811, all with colour 0xFF0000.
  - fill_done pulses once, the cycle after pixel 4811; fill_busy then drops.
- Clipping: x0=798, y0=599, w=5, h=3.
  - Required: exactly two writes, pixels 479998 and 479999, then fill_done.
- Empty command: w=0.
  - Required: no fb_write; fill_busy high for 2 cycles; fill_done in the 2nd of those cycles.
- Starvation guard: CPU_BURST=4, fill of 1x20 running, cpu_req tied high with new data after every ack.
  - Required: pattern CPU, fill, CPU, fill... (the CPU eligible every other cycle).
  - With the ack gap removed via a model of back-to-back eligibility, never more than 4 consecutive CPU writes while the fill is pending.
  - All 20 fill pixels are written, in order.
- Busy rejection: second fill_start in the middle of a 4x4 fill.
  - Required: ignored; only the original 16 pixels are written; a single fill_done.
- Reset mid-fill: assert reset after the 3rd write of an 8x1 fill.
  - Required: all outputs 0 within the reset window and no writes after release.
  - A new 1x1 fill at (0,0) then writes pixel 0 normally.
